// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// Owner tags and lane helpers used by the FIFO and the top.
package mem_arb_pkg;

    typedef enum logic {
        OWNER_INSTR = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_e;

    typedef struct packed {
        owner_e     owner;
        logic [1:0] lane;
    } owner_entry_t;

    localparam int MEM_BE_W = 16;
    localparam int WORD_W   = 32;

    function automatic logic [MEM_BE_W-1:0] lane_be(
        input logic [3:0] be,
        input logic [1:0] lane
    );
        return MEM_BE_W'(be) << {lane, 2'b00};
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core fetch port, core data port and RAM port bundled together.
// slave = arbiter view, master = core/RAM environment view.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH        = 22,
    parameter int INSTR_RDATA_WIDTH = 128
);
    import mem_arb_pkg::*;

    logic                         instr_req_i;
    logic [ADDR_WIDTH-1:0]        instr_addr_i;
    logic                         instr_gnt_o;
    logic                         instr_rvalid_o;
    logic [INSTR_RDATA_WIDTH-1:0] instr_rdata_o;

    logic                         data_req_i;
    logic [ADDR_WIDTH-1:0]        data_addr_i;
    logic                         data_we_i;
    logic [3:0]                   data_be_i;
    logic [WORD_W-1:0]            data_wdata_i;
    logic                         data_gnt_o;
    logic                         data_rvalid_o;
    logic [WORD_W-1:0]            data_rdata_o;

    logic                         mem_req_o;
    logic [ADDR_WIDTH-1:0]        mem_addr_o;
    logic                         mem_we_o;
    logic [MEM_BE_W-1:0]          mem_be_o;
    logic [INSTR_RDATA_WIDTH-1:0] mem_wdata_o;
    logic                         mem_gnt_i;
    logic                         mem_rvalid_i;
    logic [INSTR_RDATA_WIDTH-1:0] mem_rdata_i;

    modport slave (
        input  instr_req_i, instr_addr_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        input  data_req_i, data_addr_i, data_we_i,
        input  data_be_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o,
        output mem_req_o, mem_addr_o, mem_we_o,
        output mem_be_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport master (
        output instr_req_i, instr_addr_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        output data_req_i, data_addr_i, data_we_i,
        output data_be_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o,
        input  mem_req_o, mem_addr_o, mem_we_o,
        input  mem_be_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

endinterface

// File: rtl/mem_port_arbiter_owner_fifo.sv
// In-order owner FIFO: records who issued each outstanding request
// so every RAM response can be steered back to its port.
module mem_arb_owner_fifo
    import mem_arb_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  owner_entry_t     entry_i,
    output owner_entry_t     entry_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    owner_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign entry_o = mem_q[rptr_q];

    // a pop in the same cycle never makes room for a push
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = ptr_inc(wptr_q);
        if (do_pop)  rptr_d = ptr_inc(rptr_q);
        if (do_push & ~do_pop)      count_d = count_q + 1'b1;
        else if (~do_push & do_pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            if (do_push) mem_q[wptr_q] <= entry_i;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter onto one 128-bit single-port RAM, in-order responses.
// MEM_ARB_ROUND_ROBIN_EN: round-robin ties; otherwise DATA wins ties.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int ADDR_WIDTH        = 22,
    parameter  int INSTR_RDATA_WIDTH = 128,
    parameter  int MAX_OUTSTANDING   = 2,
    localparam int CNT_W             = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic clk_i,
    input  logic rstn_i,
    mem_port_arbiter_if.slave bus
);

    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        {{(ADDR_WIDTH-4){1'b1}}, 4'b0000};

    logic                         slot_free;
    logic                         instr_elig, data_elig;
    logic                         tie_data, sel_data;
    logic                         gnt, pop;
    logic [ADDR_WIDTH-1:0]        sel_addr;
    logic [INSTR_RDATA_WIDTH-1:0] line;
    owner_entry_t                 push_entry, head;
    logic                         fifo_full, fifo_empty;
    logic [CNT_W-1:0]             fifo_count;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_e last_q, last_d;

    assign tie_data = (last_q == OWNER_INSTR);

    always_comb begin
        last_d = last_q;
        if (gnt) last_d = sel_data ? OWNER_DATA : OWNER_INSTR;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) last_q <= OWNER_DATA;
        else         last_q <= last_d;
    end
`else
    assign tie_data = 1'b1;
`endif

    assign slot_free  = (fifo_count < CNT_W'(MAX_OUTSTANDING));
    assign instr_elig = bus.instr_req_i & slot_free;
    assign data_elig  = bus.data_req_i & slot_free;
    assign sel_data   = data_elig & (~instr_elig | tie_data);
    assign sel_addr   = sel_data ? bus.data_addr_i : bus.instr_addr_i;

    assign bus.mem_req_o   = instr_elig | data_elig;
    assign bus.mem_addr_o  = sel_addr & LINE_MASK;
    assign bus.mem_we_o    = sel_data & bus.data_we_i;
    assign bus.mem_be_o    = sel_data ?
        lane_be(bus.data_be_i, bus.data_addr_i[3:2]) : {MEM_BE_W{1'b1}};
    assign bus.mem_wdata_o = {4{bus.data_wdata_i}};

    assign gnt             = bus.mem_gnt_i & bus.mem_req_o;
    assign bus.instr_gnt_o = gnt & ~sel_data;
    assign bus.data_gnt_o  = gnt & sel_data;

    assign push_entry.owner = sel_data ? OWNER_DATA : OWNER_INSTR;
    assign push_entry.lane  = sel_addr[3:2];

    // responses with nothing outstanding are dropped here
    assign pop  = bus.mem_rvalid_i & ~fifo_empty;
    assign line = bus.mem_rdata_i;

    assign bus.instr_rvalid_o = pop & (head.owner == OWNER_INSTR);
    assign bus.instr_rdata_o  = line;
    assign bus.data_rvalid_o  = pop & (head.owner == OWNER_DATA);
    assign bus.data_rdata_o   = line[WORD_W*head.lane +: WORD_W];

    mem_arb_owner_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (gnt & ~fifo_full),
        .pop_i   (pop),
        .entry_i (push_entry),
        .entry_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule
